dct_transpose_buf: RTL
======================

Name: dct_transpose_buf

Overview:
- Sits between the row (1x8) DCT stage and the column DCT stage of the JPEG encoder.
- Collects 8 consecutive lines of row-DCT coefficients into a ping-pong buffer.
- Re-emits each 8-line strip in 8x8-block, column-major order, so the next stage can apply a 1x8 window that is vertical in the image.
- One bank fills while the other drains, sustaining 1 word/clock once primed.

Parameters:
- TDATA_WIDTH, 24: coefficient container width in bits. Multiple of 8. Values are opaque to this block.
- MAX_LINE_WIDTH, 1920: maximum words per line. Multiple of 8.
- BLK, 8: block dimension. Fixed; taken from the package constant.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset: asynchronous, active-high.
- dct_i  axi4_stream_if.slave  TDATA_WIDTH  raster-order row-DCT words. tuser = first word of frame; tlast = last word of line.
- dct_o  axi4_stream_if.master  TDATA_WIDTH  block column-major words. tuser = first word of frame; tlast = last word of strip.

Behaviour:
- Storage: one simple-dual-port RAM, depth 2*BLK*MAX_LINE_WIDTH.
  - Write address = bank*BLK*MAX + row*MAX + x.
  - 1-cycle read latency.
  - Per-bank state: full flag, tuser flag, latched line width W.
- Write side:
  - dct_i.tready = !full[wr_bank].
  - On each handshake, write at (row, x), then x++.
  - On tlast: x <= 0, row++. On row 0, latch W = x+1 into the bank.
  - On tlast with row == 7: set full[wr_bank], toggle wr_bank, row <= 0.
  - A tuser handshake sets tuser_flag[wr_bank].
- Read side (counters blk, col, r):
  - Starts when full[rd_bank] is set.
  - Read address = r*MAX + blk*8 + col. r increments fastest, then col, then blk. blk runs 0..W/8-1.
  - Emitted word k of a block is the element at row k%8, column k/8.
- Read pipeline:
  - Two stages: RAM read, then output register.
  - Both stages advance on data_path_ready = !dct_o.tvalid || dct_o.tready.
  - tvalid, tuser and tlast are pipelined alongside the data.
  - Latency: first dct_o.tvalid 2 cycles after the bank-full flag is seen by the reader (3 clocks after the last write handshake).
- Output flags:
  - tuser on the first word of a drained bank whose tuser_flag is set.
  - tlast on the last word: blk = W/8-1, col = 7, r = 7.
- Bank release:
  - When the last read address of a bank is issued: clear full[rd_bank] and tuser_flag[rd_bank], toggle rd_bank.
  - The next bank's read may be issued the following cycle; no bubble between strips.
- Simultaneous set/clear: the writer setting full on one bank and the reader clearing full on the other in the same cycle are both honoured. Set-on-same-bank cannot occur.
- Backpressure: with dct_o.tready low, the output holds data, tvalid, tuser and tlast stable and the read counters freeze.
- Reset values:
  - dct_o.tvalid/tuser/tlast = 0, dct_i.tready = 1.
  - All counters and bank pointers = 0; full and tuser flags = 0.
  - RAM contents are not cleared.
  - A reset mid-fill or mid-drain discards the partial strip.
- dct_o.tkeep and dct_o.tstrb are tied to '1.
- Unsupported input, outside the contract and not checked:
  - W not a multiple of 8.
  - W > MAX_LINE_WIDTH.
  - Rows of one strip with differing widths.
  - Frame height not a multiple of 8.

Decomposition:
- dct_pkg gains:
  - BLK_SIZE = 8.
  - A function computing container width from PX_WIDTH/COEF_FRACT_WIDTH, shared with the row stage for TDATA_WIDTH.
- Sub-module dct_tbuf_ram: parameterised simple dual-port RAM (write port; read port with registered output and read enable). Instantiated once.
- Control (write FSM, read counters, flags, output pipeline) stays in dct_transpose_buf.

Test Plan:
- W=16, one strip, data = row*16+x, tready=1. Required output order:
  - 0, 16, 32, …, 112, 1, 17, … (block 0), then 8, 24, …
  - 128 words total; tlast only on word 127 (value 127); tuser on word 0 if driven on input word 0.
- Two back-to-back strips at W=32 with continuous input:
  - dct_i.tready never drops during the second strip's fill.
  - Output is gap-free across the strip boundary.
  - tuser appears only on strip 1.
- Random tready on dct_o (50%) and random tvalid on dct_i:
  - Output sequence is identical to the no-stall run.
  - No word is lost or duplicated; outputs are stable while stalled.
- Both banks full with dct_o.tready held low: dct_i.tready=0 until the first bank fully drains, then reasserts within 1 cycle.
- Width change between strips (W=8, then W=24):
  - Strip 1 emits 64 words, tlast at word 63.
  - Strip 2 emits 192 words, tlast at word 191.
- Assert rst_i mid-drain (word 40 of 128), then send a new strip:
  - Outputs go to 0 immediately; no stale words are emitted.
  - The new strip is output correctly from word 0.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: constants and helpers shared by the JPEG DCT pipeline stages.
//   BLK_SIZE              - block dimension (8x8 blocks).
//   PX_WIDTH              - input pixel width.
//   COEF_FRACT_WIDTH      - fractional bits carried by the DCT coefficients.
//   tbuf_side_t           - sideband bits travelling beside data in the transpose buffer.
//   coef_container_width  - coefficient container width, rounded to whole bytes.
package dct_pkg;

    localparam int BLK_SIZE         = 8;
    localparam int PX_WIDTH         = 8;
    localparam int COEF_FRACT_WIDTH = 12;

    typedef struct packed {
        logic valid;
        logic user;
        logic last;
    } tbuf_side_t;

    // Sign bit plus 3 bits of growth from the 8-point 1-D DCT, then rounded
    // up to a byte multiple so the value fits an AXI4-Stream tdata field.
    function automatic int coef_container_width(input int px_width, input int fract_width);
        int raw_bits;
        raw_bits = px_width + 32'sd1 + 32'sd3 + fract_width;
        return ((raw_bits + 32'sd7) / 32'sd8) * 32'sd8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream bundle used between DCT pipeline stages.
//   tdata/tkeep/tstrb/tvalid/tlast/tuser flow master -> slave, tready flows back.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 24
) ();

    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic                     tuser;

    modport master (output tdata, tkeep, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tstrb, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/dct_tbuf_ram.sv
// dct_tbuf_ram: simple dual-port RAM for the DCT transpose buffer.
//   clk_i   - clock
//   wr_en   - write enable; wr_addr/wr_data written on the rising edge
//   rd_en   - read enable; rd_data updates one clock after rd_addr is presented
//   rd_data - registered read data, holds its value while rd_en is low
// Contents and the read register are intentionally not reset.
module dct_tbuf_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holding on !rd_en lets the consumer stall the pipe
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong line buffer between the row and column DCT.
// Collects 8 raster lines of row-DCT words into one bank and re-emits the
// strip 8x8 block by block, each block in column-major order, while the other
// bank fills.
//   clk_i  - clock
//   rst_i  - asynchronous, active-high reset (discards any partial strip)
//   dct_i  - raster-order input; tuser = first word of frame, tlast = end of line
//   dct_o  - block column-major output; tuser = first word of frame,
//            tlast = last word of strip; tkeep/tstrb tied high
// Line width W is latched from row 0 of each strip; W must be a multiple of 8
// and at most MAX_LINE_WIDTH (MAX_LINE_WIDTH >= 16).
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int TDATA_WIDTH    = coef_container_width(PX_WIDTH, COEF_FRACT_WIDTH),
    parameter int MAX_LINE_WIDTH = 1920
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  dct_i,
    axi4_stream_if.master dct_o
);

    localparam int BANK_WORDS = BLK_SIZE * MAX_LINE_WIDTH;
    localparam int DEPTH      = 2 * BANK_WORDS;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int X_W        = $clog2(MAX_LINE_WIDTH);
    localparam int ROW_W      = $clog2(BLK_SIZE);
    localparam int BLK_W      = X_W - ROW_W;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_SIZE - 1);

    // Write side state
    logic                wr_bank_r;
    logic [ROW_W-1:0]    row_r;
    logic [X_W-1:0]      x_r;
    logic [1:0]          full_r;
    logic [1:0]          tuser_flag_r;
    logic [BLK_W-1:0]    last_blk_r [2];

    // Read side state
    logic                rd_bank_r;
    logic [BLK_W-1:0]    blk_r;
    logic [ROW_W-1:0]    col_r;
    logic [ROW_W-1:0]    r_r;

    // Output pipeline
    tbuf_side_t             s1_r;
    tbuf_side_t             out_r;
    logic [TDATA_WIDTH-1:0] out_data_r;

    logic                   wr_fire_s;
    logic                   strip_done_s;
    logic                   dp_ready_s;
    logic                   issue_s;
    logic                   rd_first_s;
    logic                   rd_last_s;
    logic [1:0]             full_set_s;
    logic [1:0]             tuser_set_s;
    logic [1:0]             bank_clr_s;
    logic [ADDR_W-1:0]      wr_addr_s;
    logic [ADDR_W-1:0]      rd_addr_s;
    logic [TDATA_WIDTH-1:0] ram_rdata_s;
    tbuf_side_t             s0_s;

    assign dct_i.tready = ~full_r[wr_bank_r];
    assign wr_fire_s    = dct_i.tvalid & ~full_r[wr_bank_r];
    assign strip_done_s = wr_fire_s & dct_i.tlast & (row_r == ROW_LAST);

    // Both pipeline stages move together whenever the output slot can accept
    assign dp_ready_s = ~out_r.valid | dct_o.tready;
    assign issue_s    = full_r[rd_bank_r] & dp_ready_s;

    assign rd_first_s = (blk_r == BLK_W'(0)) & (col_r == ROW_W'(0)) & (r_r == ROW_W'(0));
    assign rd_last_s  = (blk_r == last_blk_r[rd_bank_r]) & (col_r == ROW_LAST) & (r_r == ROW_LAST);

    assign wr_addr_s = ADDR_W'(BANK_WORDS) * ADDR_W'(wr_bank_r)
                     + ADDR_W'(MAX_LINE_WIDTH) * ADDR_W'(row_r)
                     + ADDR_W'(x_r);
    // {blk, col} is blk*8 + col
    assign rd_addr_s = ADDR_W'(BANK_WORDS) * ADDR_W'(rd_bank_r)
                     + ADDR_W'(MAX_LINE_WIDTH) * ADDR_W'(r_r)
                     + ADDR_W'({blk_r, col_r});

    // Per-bank set/clear requests; writer and reader always address different banks
    always_comb begin
        full_set_s  = 2'b00;
        tuser_set_s = 2'b00;
        bank_clr_s  = 2'b00;
        if (strip_done_s) begin
            full_set_s[wr_bank_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        if (wr_fire_s && dct_i.tuser) begin
            tuser_set_s[wr_bank_r] = 1'b1;
        end else begin
            tuser_set_s = 2'b00;
        end
        if (issue_s && rd_last_s) begin
            bank_clr_s[rd_bank_r] = 1'b1;
        end else begin
            bank_clr_s = 2'b00;
        end
    end

    // Sideband for the read being issued this cycle
    always_comb begin
        s0_s       = '0;
        s0_s.valid = issue_s;
        s0_s.user  = issue_s & rd_first_s & tuser_flag_r[rd_bank_r];
        s0_s.last  = issue_s & rd_last_s;
    end

    // Bank full and frame-start flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_r       <= 2'b00;
            tuser_flag_r <= 2'b00;
        end else begin
            full_r       <= (full_r & ~bank_clr_s) | full_set_s;
            tuser_flag_r <= (tuser_flag_r & ~bank_clr_s) | tuser_set_s;
        end
    end

    // Write position within the filling bank and per-bank line width capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_r     <= 1'b0;
            row_r         <= ROW_W'(0);
            x_r           <= X_W'(0);
            last_blk_r[0] <= BLK_W'(0);
            last_blk_r[1] <= BLK_W'(0);
        end else if (wr_fire_s) begin
            if (dct_i.tlast) begin
                x_r   <= X_W'(0);
                row_r <= row_r + ROW_W'(1);
                // W = x+1 is a multiple of 8, so x>>3 is the last block index
                if (row_r == ROW_W'(0)) begin
                    last_blk_r[wr_bank_r] <= x_r[X_W-1:ROW_W];
                end
                if (row_r == ROW_LAST) begin
                    wr_bank_r <= ~wr_bank_r;
                end
            end else begin
                x_r <= x_r + X_W'(1);
            end
        end
    end

    // Read counters: row fastest, then column, then block; bank flips on the last read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_bank_r <= 1'b0;
            blk_r     <= BLK_W'(0);
            col_r     <= ROW_W'(0);
            r_r       <= ROW_W'(0);
        end else if (issue_s) begin
            r_r <= r_r + ROW_W'(1);
            if (r_r == ROW_LAST) begin
                col_r <= col_r + ROW_W'(1);
                if (col_r == ROW_LAST) begin
                    if (rd_last_s) begin
                        blk_r     <= BLK_W'(0);
                        rd_bank_r <= ~rd_bank_r;
                    end else begin
                        blk_r <= blk_r + BLK_W'(1);
                    end
                end
            end
        end
    end

    // Two-stage read pipeline: RAM read stage, then the output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_r       <= '0;
            out_r      <= '0;
            out_data_r <= TDATA_WIDTH'(0);
        end else if (dp_ready_s) begin
            s1_r       <= s0_s;
            out_r      <= s1_r;
            out_data_r <= ram_rdata_s;
        end
    end

    dct_tbuf_ram #(
        .DATA_WIDTH (TDATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (wr_fire_s),
        .wr_addr (wr_addr_s),
        .wr_data (dct_i.tdata),
        .rd_en   (issue_s),
        .rd_addr (rd_addr_s),
        .rd_data (ram_rdata_s)
    );

    assign dct_o.tdata  = out_data_r;
    assign dct_o.tvalid = out_r.valid;
    assign dct_o.tuser  = out_r.user;
    assign dct_o.tlast  = out_r.last;
    assign dct_o.tkeep  = '1;
    assign dct_o.tstrb  = '1;

endmodule
